nec_receiver: RTL and testbench



---
 rtl/nec_receiver.sv | 228 ++++++++++++++++++++++
 tb/tb_nec_receiver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/nec_receiver.sv
// NEC IR frame decoder.
// Measures mark/space durations of the demodulated IR envelope in microseconds,
// validates leader, 32 LSB-first data bits and the stop mark, and reports
// decoded address/command (valid), repeat frames (rpt) and aborted frames (err).
// Optional build macro: NEC_INVERSE_CHECK_EN -- when defined, the inverted
// address/command bytes must match or the frame is rejected with err.
module nec_receiver #(
  parameter int CLKS_PER_US = 125,
  parameter int CNT_W       = 14
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ir_in,
  output logic [7:0] addr,
  output logic [7:0] code,
  output logic       valid,
  output logic       rpt,
  output logic       err,
  output logic       busy
);

  localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_US - 1);
  localparam logic [CNT_W-1:0] US_SAT  = '1;

  // Duration windows in microseconds, inclusive on both ends.
  localparam logic [CNT_W-1:0] LEAD_MARK_MIN  = CNT_W'(8000);
  localparam logic [CNT_W-1:0] LEAD_MARK_MAX  = CNT_W'(10000);
  localparam logic [CNT_W-1:0] LEAD_DATA_MIN  = CNT_W'(4000);
  localparam logic [CNT_W-1:0] LEAD_DATA_MAX  = CNT_W'(5000);
  localparam logic [CNT_W-1:0] LEAD_RPT_MIN   = CNT_W'(1750);
  localparam logic [CNT_W-1:0] LEAD_RPT_MAX   = CNT_W'(2750);
  localparam logic [CNT_W-1:0] SHORT_MIN      = CNT_W'(400);
  localparam logic [CNT_W-1:0] SHORT_MAX      = CNT_W'(750);
  localparam logic [CNT_W-1:0] ONE_SPACE_MIN  = CNT_W'(1400);
  localparam logic [CNT_W-1:0] ONE_SPACE_MAX  = CNT_W'(2000);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } state_t;

  state_t           state, state_next;
  logic             sync1, sync2, ir_dly;
  logic             rise, fall;
  logic [PRE_W-1:0] pre_cnt;
  logic [CNT_W-1:0] us_cnt;
  logic [31:0]      sr, sr_next;
  logic [4:0]       bit_idx, bit_idx_next;
  logic             rpt_flag, rpt_flag_next;
  logic             valid_next, rpt_next, err_next, load;
  logic             bit_ok;

  function automatic logic in_win(input logic [CNT_W-1:0] v,
                                  input logic [CNT_W-1:0] lo,
                                  input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  assign rise = sync2 & ~ir_dly;
  assign fall = ~sync2 & ir_dly;
  assign busy = (state != IDLE);

  // Two-flop synchronizer plus a delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      ir_dly <= 1'b0;
    end else begin
      sync1  <= ir_in;
      sync2  <= sync1;
      ir_dly <= sync2;
    end
  end

  // Microsecond timebase; restarts on every envelope edge and idles at zero.
  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE || rise || fall) begin
      pre_cnt <= '0;
      us_cnt  <= '0;
    end else if (pre_cnt == PRE_MAX) begin
      pre_cnt <= '0;
      if (us_cnt != US_SAT) us_cnt <= us_cnt + 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

`ifdef NEC_INVERSE_CHECK_EN
  logic inv_ok;
  assign inv_ok = (sr[15:8] == ~sr[7:0]) && (sr[31:24] == ~sr[23:16]);
`else
  // Inverse bytes are captured but deliberately not checked in this build.
  logic unused_inv;
  assign unused_inv = ^{sr[15:8], sr[31:24]};
`endif

  // State register, shift register and registered output pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sr       <= '0;
      bit_idx  <= '0;
      rpt_flag <= 1'b0;
      addr     <= '0;
      code     <= '0;
      valid    <= 1'b0;
      rpt      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      sr       <= sr_next;
      bit_idx  <= bit_idx_next;
      rpt_flag <= rpt_flag_next;
      valid    <= valid_next;
      rpt      <= rpt_next;
      err      <= err_next;
      if (load) begin
        addr <= sr[7:0];
        code <= sr[23:16];
      end
    end
  end

  // Next-state logic: duration checks on edges, timeouts while waiting.
  always_comb begin
    state_next    = state;
    sr_next       = sr;
    bit_idx_next  = bit_idx;
    rpt_flag_next = rpt_flag;
    valid_next    = 1'b0;
    rpt_next      = 1'b0;
    err_next      = 1'b0;
    load          = 1'b0;
    bit_ok        = 1'b0;

    case (state)
      IDLE: begin
        if (rise) state_next = LEAD_MARK;
      end

      LEAD_MARK: begin
        if (fall) begin
          if (in_win(us_cnt, LEAD_MARK_MIN, LEAD_MARK_MAX)) state_next = LEAD_SPACE;
          else begin err_next = 1'b1; state_next = IDLE; end
        end else if (us_cnt > LEAD_MARK_MAX) begin
          err_next = 1'b1; state_next = IDLE;
        end
      end

      LEAD_SPACE: begin
        if (rise) begin
          if (in_win(us_cnt, LEAD_DATA_MIN, LEAD_DATA_MAX)) begin
            bit_idx_next  = '0;
            rpt_flag_next = 1'b0;
            state_next    = BIT_MARK;
          end else if (in_win(us_cnt, LEAD_RPT_MIN, LEAD_RPT_MAX)) begin
            rpt_flag_next = 1'b1;
            state_next    = STOP_MARK;
          end else begin
            err_next = 1'b1; state_next = IDLE;
          end
        end else if (us_cnt > LEAD_DATA_MAX) begin
          err_next = 1'b1; state_next = IDLE;
        end
      end

      BIT_MARK: begin
        if (fall) begin
          if (in_win(us_cnt, SHORT_MIN, SHORT_MAX)) state_next = BIT_SPACE;
          else begin err_next = 1'b1; state_next = IDLE; end
        end else if (us_cnt > SHORT_MAX) begin
          err_next = 1'b1; state_next = IDLE;
        end
      end

      BIT_SPACE: begin
        if (rise) begin
          if (in_win(us_cnt, SHORT_MIN, SHORT_MAX)) begin
            sr_next[bit_idx] = 1'b0;
            bit_ok           = 1'b1;
          end else if (in_win(us_cnt, ONE_SPACE_MIN, ONE_SPACE_MAX)) begin
            sr_next[bit_idx] = 1'b1;
            bit_ok           = 1'b1;
          end else begin
            err_next = 1'b1; state_next = IDLE;
          end
          if (bit_ok) begin
            if (bit_idx == 5'd31) state_next = STOP_MARK;
            else begin
              bit_idx_next = bit_idx + 1'b1;
              state_next   = BIT_MARK;
            end
          end
        end else if (us_cnt > ONE_SPACE_MAX) begin
          err_next = 1'b1; state_next = IDLE;
        end
      end

      STOP_MARK: begin
        if (fall) begin
          state_next = IDLE;
          if (!in_win(us_cnt, SHORT_MIN, SHORT_MAX)) err_next = 1'b1;
          else if (rpt_flag) rpt_next = 1'b1;
          else begin
`ifdef NEC_INVERSE_CHECK_EN
            if (inv_ok) begin valid_next = 1'b1; load = 1'b1; end
            else err_next = 1'b1;
`else
            valid_next = 1'b1;
            load       = 1'b1;
`endif
          end
        end else if (us_cnt > SHORT_MAX) begin
          err_next = 1'b1; state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nec_receiver.sv
// Directed testbench for nec_receiver at 2 clocks per microsecond.
// Expectations follow the NEC_INVERSE_CHECK_EN build macro when it is defined.
module tb_nec_receiver;

  localparam int CPU = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ir_in;
  logic [7:0] addr, code;
  logic       valid, rpt, err, busy;

  int tests = 0, failures = 0;
  int valid_cnt = 0, rpt_cnt = 0, err_cnt = 0, overlap_cnt = 0;

  nec_receiver #(.CLKS_PER_US(CPU), .CNT_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .ir_in(ir_in),
    .addr(addr), .code(code), .valid(valid), .rpt(rpt), .err(err), .busy(busy)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Pulse monitor: counts high cycles of each pulse and any overlapping cycles.
  always @(negedge clk) begin
    if (valid) valid_cnt++;
    if (rpt)   rpt_cnt++;
    if (err)   err_cnt++;
    if ((int'(valid) + int'(rpt) + int'(err)) > 1) overlap_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic level, input int us);
    ir_in = level;
    repeat (us * CPU) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      hold(1'b1, 500);
      hold(1'b0, w[i] ? 1500 : 500);
    end
  endtask

  task automatic send_frame(input logic [31:0] w);
    hold(1'b1, 8500);
    hold(1'b0, 4250);
    send_bits(w, 32);
    hold(1'b1, 500);
    hold(1'b0, 1000);
  endtask

  // Linear directed sequence.
  initial begin
    ir_in = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_addr", addr, 8'h00);
    check_output("reset_code", code, 8'h00);
    check_output("reset_flags", {valid, rpt, err, busy}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Ideal frame 00 FF 30 CF with latency and pulse-width checks.
    hold(1'b1, 8500);
    check_output("busy_in_leader", busy, 1'b1);
    hold(1'b0, 4250);
    send_bits(32'hCF30_FF00, 32);
    hold(1'b1, 500);
    ir_in = 1'b0;
    repeat (2) @(negedge clk);
    check_output("valid_too_early", valid, 1'b0);
    @(negedge clk);
    check_output("valid_latency", valid, 1'b1);
    check_output("frame1_addr", addr, 8'h00);
    check_output("frame1_code", code, 8'h30);
    @(negedge clk);
    check_output("valid_one_cycle", valid, 1'b0);
    hold(1'b0, 1000);
    check_output("frame1_valid_cnt", valid_cnt, 1);
    check_output("frame1_err_cnt", err_cnt, 0);
    check_output("frame1_busy", busy, 1'b0);

    // Repeat frame.
    hold(1'b1, 8500);
    hold(1'b0, 2250);
    hold(1'b1, 500);
    hold(1'b0, 1000);
    check_output("repeat_rpt_cnt", rpt_cnt, 1);
    check_output("repeat_valid_cnt", valid_cnt, 1);
    check_output("repeat_addr", addr, 8'h00);
    check_output("repeat_code", code, 8'h30);

    // Bit 5 mark stretched to 1000 us, then abandon the frame.
    hold(1'b1, 8500);
    hold(1'b0, 4250);
    send_bits(32'hED12_5AA5, 5);
    hold(1'b1, 1000);
    hold(1'b0, 2000);
    check_output("longmark_err_cnt", err_cnt, 1);
    check_output("longmark_valid_cnt", valid_cnt, 1);
    check_output("longmark_busy", busy, 1'b0);

    // Recovery frame A5 5A 12 ED.
    send_frame(32'hED12_5AA5);
    check_output("recover_valid_cnt", valid_cnt, 2);
    check_output("recover_addr", addr, 8'hA5);
    check_output("recover_code", code, 8'h12);
    check_output("recover_err_cnt", err_cnt, 1);

    // Short leader mark.
    hold(1'b1, 3000);
    hold(1'b0, 2000);
    check_output("short_leader_err_cnt", err_cnt, 2);
    check_output("short_leader_busy", busy, 1'b0);

    // Leader space held past 5000 us with no further edges.
    hold(1'b1, 8500);
    hold(1'b0, 6000);
    check_output("space_timeout_err_cnt", err_cnt, 3);
    check_output("space_timeout_busy", busy, 1'b0);
    check_output("space_timeout_valid_cnt", valid_cnt, 2);

    // Reset asserted for one cycle during bit 16.
    hold(1'b1, 8500);
    hold(1'b0, 4250);
    send_bits(32'h0034_ED12, 16);
    hold(1'b1, 500);
    hold(1'b0, 100);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("midreset_addr", addr, 8'h00);
    check_output("midreset_code", code, 8'h00);
    check_output("midreset_flags", {valid, rpt, err, busy}, 4'b0000);
    rst_n = 1'b1;
    hold(1'b0, 3000);
    check_output("midreset_err_cnt", err_cnt, 3);
    check_output("midreset_valid_cnt", valid_cnt, 2);

    // Fresh frame 12 ED 34 00: command inverse byte is wrong.
    send_frame(32'h0034_ED12);
`ifdef NEC_INVERSE_CHECK_EN
    check_output("inv_err_cnt", err_cnt, 4);
    check_output("inv_valid_cnt", valid_cnt, 2);
    check_output("inv_addr", addr, 8'h00);
    check_output("inv_code", code, 8'h00);
`else
    check_output("noinv_valid_cnt", valid_cnt, 3);
    check_output("noinv_addr", addr, 8'h12);
    check_output("noinv_code", code, 8'h34);
    check_output("noinv_err_cnt", err_cnt, 3);
`endif

    check_output("final_rpt_cnt", rpt_cnt, 1);
    check_output("pulse_overlap", overlap_cnt, 0);
    check_output("final_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
